// File: rtl/lc330_pkg.sv
// Shared constants, FSM encoding and HALT-decode helper for the LC330 memory responder.
package lc330_pkg;

    localparam int WORD_W = 32;
    localparam int OPC_HI = 24;
    localparam int OPC_LO = 22;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_halt(input logic [WORD_W-1:0] word);
        return (word[OPC_HI:OPC_LO] == OP_HALT);
    endfunction

endpackage

// File: rtl/lc330_mem_array.sv
// Word storage with synchronous write and a registered read port; storage is never reset,
// only the read register is.
module lc330_mem_array
    import lc330_pkg::*;
#(
    parameter int    DEPTH     = 65536,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // Storage write port; deliberately outside the reset domain so committed data survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: loads the addressed word, or is zeroed for writes and out-of-range accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else if (clr) begin
            rdata_r <= {WORD_W{1'b0}};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/lc330_mem_responder.sv
// LC330 memory responder: single-outstanding request/response target with programmable
// latency, range checking, HALT detection and completion counters.
module lc330_mem_responder
    import lc330_pkg::*;
#(
    parameter int    DEPTH     = 65536,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              halt_seen,
    output logic [WORD_W-1:0] rd_count,
    output logic [WORD_W-1:0] wr_count
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    state_e              state_r, state_nx_s;
    logic [3:0]          lat_cnt_r, lat_nx_s;
    logic                accept_s, done_s, in_range_s;
    logic                req_ready_r, rsp_valid_r, rsp_err_r, we_r, halt_r;
    logic [WORD_W-1:0]   rd_cnt_r, wr_cnt_r, rdata_s;

    assign in_range_s = ({1'b0, req_addr} < 33'(DEPTH));

    lc330_mem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (accept_s & req_we & in_range_s),
        .re    (accept_s & ~req_we & in_range_s),
        .clr   (accept_s & ~(~req_we & in_range_s)),
        .addr  (req_addr[AW-1:0]),
        .wdata (req_wdata),
        .rdata (rdata_s)
    );

    // Next-state, latency countdown, acceptance and completion decode.
    always_comb begin
        state_nx_s = state_r;
        lat_nx_s   = lat_cnt_r;
        accept_s   = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_WAIT;
                        lat_nx_s   = LAT_INIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r <= 4'd1) begin
                    state_nx_s = ST_RESP;
                end else begin
                    lat_nx_s = lat_cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM, handshake flags and per-request attributes captured at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            we_r        <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            lat_cnt_r   <= lat_nx_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= (state_nx_s == ST_RESP);
            if (accept_s) begin
                rsp_err_r <= ~in_range_s;
                we_r      <= req_we;
            end else begin
                rsp_err_r <= rsp_err_r;
                we_r      <= we_r;
            end
        end
    end

    // Completion statistics; error responses are counted like any other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
            halt_r   <= 1'b0;
        end else if (done_s) begin
            rd_cnt_r <= we_r ? rd_cnt_r : rd_cnt_r + 32'd1;
            wr_cnt_r <= we_r ? wr_cnt_r + 32'd1 : wr_cnt_r;
            halt_r   <= halt_r | (~we_r & ~rsp_err_r & is_halt(rdata_s));
        end else begin
            rd_cnt_r <= rd_cnt_r;
            wr_cnt_r <= wr_cnt_r;
            halt_r   <= halt_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_s;
    assign rsp_err   = rsp_err_r;
    assign halt_seen = halt_r;
    assign rd_count  = rd_cnt_r;
    assign wr_count  = wr_cnt_r;

endmodule

// File: tb/tb_lc330_mem_responder.sv
// Scoreboard bench for lc330_mem_responder: a DEPTH=16/LATENCY=2 instance for function,
// plus LATENCY=1 and LATENCY=15 instances for latency measurement.
module tb_lc330_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, halt_seen;
    logic [31:0] rsp_rdata, rd_count, wr_count;

    logic [1:0]  lq_valid, lq_ready, lq_rspv, lq_err, lq_halt;
    logic [31:0] lq_rdata [2];
    logic [31:0] lq_rdc [2];
    logic [31:0] lq_wrc [2];
    logic [31:0] lq_addr = 32'd2;
    logic [31:0] lq_wdata = 32'd0;
    logic        lq_we = 1'b0;
    logic        lq_rr = 1'b1;

    exp_t        sb [$];
    logic [31:0] mdl [16];
    logic [31:0] exp_rd, exp_wr;
    logic        exp_halt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    lc330_mem_responder #(.DEPTH(16), .LATENCY(2), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .halt_seen(halt_seen),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    for (genvar g = 0; g < 2; g++) begin : g_lat
        lc330_mem_responder #(.DEPTH(16), .LATENCY((g == 0) ? 1 : 15), .INIT_FILE("")) u_lat (
            .clk(clk), .rst(rst), .req_valid(lq_valid[g]), .req_ready(lq_ready[g]), .req_we(lq_we),
            .req_addr(lq_addr), .req_wdata(lq_wdata), .rsp_valid(lq_rspv[g]), .rsp_ready(lq_rr),
            .rsp_rdata(lq_rdata[g]), .rsp_err(lq_err[g]), .halt_seen(lq_halt[g]),
            .rd_count(lq_rdc[g]), .wr_count(lq_wrc[g])
        );
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction on the main instance; hold > 0 keeps rsp_ready low that many cycles in RESP.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold);
        exp_t e, o;
        int   lat;
        bit   ok;
        e.err   = (addr >= 32'd16);
        e.rdata = (we || e.err) ? 32'd0 : mdl[addr[3:0]];
        if (we && !e.err) mdl[addr[3:0]] = wdata;
        sb.push_back(e);
        rsp_ready = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin chk_val("ready_timeout", 32'd0, 32'd1); return; end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lat++;
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
        end
        if (!ok) begin chk_val("rsp_timeout", 32'd0, 32'd1); return; end
        chk_val("latency", 32'(lat), 32'd2);
        o = sb.pop_front();
        chk_val("rdata", rsp_rdata, o.rdata);
        chk_val("err", {31'd0, rsp_err}, {31'd0, o.err});
        chk_val("halt_pre", {31'd0, halt_seen}, {31'd0, exp_halt});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 req_valid = ~req_valid; req_we = 1'b0; req_addr = $urandom_range(0, 15);
            @(negedge clk);
            chk_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk_val("hold_rdata", rsp_rdata, o.rdata);
            chk_val("hold_err", {31'd0, rsp_err}, {31'd0, o.err});
            chk_val("hold_ready", {31'd0, req_ready}, 32'd0);
            chk_val("hold_rdcnt", rd_count, exp_rd);
            chk_val("hold_wrcnt", wr_count, exp_wr);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        if (we) exp_wr++; else exp_rd++;
        if (!we && !o.err && o.rdata[24:22] == 3'b110) exp_halt = 1'b1;
        @(negedge clk);
        chk_val("rd_count", rd_count, exp_rd);
        chk_val("wr_count", wr_count, exp_wr);
        chk_val("halt_post", {31'd0, halt_seen}, {31'd0, exp_halt});
        chk_val("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Acceptance-to-rsp_valid cycle count on a latency instance (rsp_ready tied high).
    task automatic measure_lat(input int k, input int exp_lat);
        int lat;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lq_ready[k]) begin ok = 1'b1; break; end
        end
        if (!ok) begin chk_val("lq_ready_timeout", 32'd0, 32'd1); return; end
        lq_valid[k] = 1'b1;
        @(posedge clk);
        #1 lq_valid[k] = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lat++;
            @(negedge clk);
            if (lq_rspv[k]) begin ok = 1'b1; break; end
            @(posedge clk);
        end
        if (!ok) begin chk_val("lq_rsp_timeout", 32'd0, 32'd1); return; end
        chk_val($sformatf("lat%0d", exp_lat), 32'(lat), 32'(exp_lat));
        @(posedge clk);
        @(negedge clk);
        chk_val($sformatf("lat%0d_rdcnt", exp_lat), lq_rdc[k], 32'd1);
        chk_val($sformatf("lat%0d_ready", exp_lat), {31'd0, lq_ready[k]}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1; lq_valid = 2'b00;
        exp_rd = 32'd0; exp_wr = 32'd0; exp_halt = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("rst_rdata", rsp_rdata, 32'd0);
        chk_val("rst_err", {31'd0, rsp_err}, 32'd0);
        chk_val("rst_halt", {31'd0, halt_seen}, 32'd0);
        chk_val("rst_rdcnt", rd_count, 32'd0);
        chk_val("rst_wrcnt", wr_count, 32'd0);
        rst = 1'b1;

        run_txn(1'b1, 32'd5, 32'h1234_5678, 0);
        run_txn(1'b0, 32'd5, 32'd0, 0);
        run_txn(1'b1, 32'd7, 32'h0180_0000, 0);
        run_txn(1'b1, 32'd8, 32'h0040_0000, 0);
        run_txn(1'b0, 32'd7, 32'd0, 0);
        run_txn(1'b0, 32'd8, 32'd0, 0);
        run_txn(1'b1, 32'd0, 32'hCAFE_F00D, 0);
        run_txn(1'b1, 32'd16, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 32'd16, 32'd0, 0);
        run_txn(1'b0, 32'h8000_0000, 32'd0, 0);
        run_txn(1'b0, 32'd0, 32'd0, 0);
        run_txn(1'b1, 32'd9, 32'h5A5A_A5A5, 0);
        run_txn(1'b0, 32'd9, 32'd0, 5);

        // Reset in WAIT of an accepted write: it stays committed.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_val("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk_val("mid_rst_rdcnt", rd_count, 32'd0);
        chk_val("mid_rst_wrcnt", wr_count, 32'd0);
        chk_val("mid_rst_halt", {31'd0, halt_seen}, 32'd0);
        mdl[3] = 32'h0000_00AA;
        exp_rd = 32'd0; exp_wr = 32'd0; exp_halt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b0, 32'd3, 32'd0, 0);

        measure_lat(0, 1);
        measure_lat(1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
